// File: rtl/seg7_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pkg : shared types and helpers for the BCD converter.   Rev 1.0
// ---------------------------------------------------------------------------
package seg7_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bits needed to hold WIDTH-1 in the bit counter; never narrower than 1.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_adj_digit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_adj_digit : add-3-if->=5 correction for one BCD digit.   Rev 1.0
// ---------------------------------------------------------------------------
module bcd_adj_digit
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] din,
   output logic [DIGIT_W-1:0] dout
);

   assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_conv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_bcd_conv : serial double-dabble binary-to-BCD, one bit per clock.   Rev 1.0
// ---------------------------------------------------------------------------
module seg7_bcd_conv
   import seg7_pkg::*;
#(
   parameter int DIGITS = 6,
   parameter int WIDTH  = 20
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WIDTH-1:0]                 in_value,
   output logic [DIGITS-1:0][DIGIT_W-1:0]   digits,
   output logic                             ovf,
   output logic                             done
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam int BCD_W = DIGITS * DIGIT_W;

   state_t                            state;
   logic [CNT_W-1:0]                  cnt;
   logic [WIDTH-1:0]                  bin;
   logic [DIGITS-1:0][DIGIT_W-1:0]    bcd;
   logic                              sticky;

   logic [DIGITS-1:0][DIGIT_W-1:0]    bcd_adj;
   logic [DIGITS-1:0][DIGIT_W-1:0]    bcd_next;
   logic [WIDTH-1:0]                  bin_next;
   logic [BCD_W+WIDTH:0]              shifted;
   logic                              shift_out;
   logic                              sticky_next;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_adj_digit u_adj (
         .din  (bcd[i]),
         .dout (bcd_adj[i])
      );
   end

   // Top bit of the widened vector is the bit lost off the most significant digit.
   assign shifted     = {bcd_adj, bin, 1'b0};
   assign shift_out   = shifted[BCD_W+WIDTH];
   assign bcd_next    = shifted[BCD_W+WIDTH-1:WIDTH];
   assign bin_next    = shifted[WIDTH-1:0];
   assign sticky_next = sticky | shift_out;

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         bin    <= '0;
         bcd    <= '0;
         sticky <= 1'b0;
         digits <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bin    <= in_value;
                  bcd    <= '0;
                  sticky <= 1'b0;
                  cnt    <= CNT_W'(WIDTH - 1);
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               bin    <= bin_next;
               bcd    <= bcd_next;
               sticky <= sticky_next;
               if (cnt == '0) begin
                  ovf    <= sticky_next;
                  digits <= sticky_next ? {DIGITS{4'd9}} : bcd_next;
                  done   <= 1'b1;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/seg7_bcd_conv.md
Name: seg7_bcd_conv

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the segment display decoder: its `digits` output feeds the display's `data` input.
- Accepts a binary value over a valid/ready handshake.
- Holds the last converted decimal result stable for the display, and flags values that do not fit in DIGITS decimal digits.

Parameters:
- DIGITS, 6, number of decimal digits produced; matches the display width.
- WIDTH, 20, width of the binary input in bits; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `in_value` is valid this cycle.
- in_ready  output  1  converter is idle and will accept `in_value`.
- in_value  input  WIDTH  unsigned binary value to convert.
- digits  output  [DIGITS-1:0][3:0]  registered BCD result; digits[0] is the least significant digit.
- ovf  output  1  registered flag: the last result exceeded 10^DIGITS-1.
- done  output  1  one-cycle pulse marking that `digits`/`ovf` have just been updated.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, digits all 0, ovf 0, done 0, internal shift/BCD registers and bit counter cleared.
- After reset release, in_ready is 1.
- States:
  - IDLE: in_ready=1. An accept edge is a rising edge with in_valid && in_ready. On accept:
    - load in_value into the binary shift register;
    - clear the working BCD register and the sticky overflow bit;
    - counter = WIDTH-1;
    - go to SHIFT.
  - SHIFT: in_ready=0; in_valid is ignored. Each cycle:
    - (a) every working BCD digit >= 5 gets +3 (combinational);
    - (b) the {BCD, binary} register shifts left 1 bit;
    - (c) the bit shifted out of the top BCD digit is ORed into sticky overflow.
    - If counter==0 on this edge: commit the result, pulse done, return to IDLE. Otherwise decrement the counter.
- Commit:
  - ovf <= final sticky value.
  - If sticky is set, digits <= all 9 (saturate to 10^DIGITS-1). Otherwise digits <= the corrected-and-shifted BCD value from that same edge.
- Latency:
  - Accept at edge k; digits/ovf/done are updated at edge k+WIDTH.
  - done is high for exactly the cycle after edge k+WIDTH.
  - in_ready is low for WIDTH cycles.
- Back-to-back: in_ready is 1 in the same cycle done is 1, so a new accept is allowed there. Throughput is one conversion per WIDTH+1 cycles.
- Output hold: digits and ovf change only on commit or reset. They are never driven with intermediate values, so the display never flickers.
- Overflow: a value >= 10^DIGITS always sets ovf. A value <= 10^DIGITS-1 never sets ovf.
- Full-range example: with defaults, 1048575 gives ovf=1 and digits 999999.
- Reset during SHIFT: the conversion is abandoned; outputs return to reset values and no done pulse is issued.
- in_value is sampled only on the accept edge; changes during SHIFT have no effect.

Decomposition:
- Package seg7_pkg:
  - localparam DIGIT_W = 4;
  - a state enum {IDLE, SHIFT};
  - a function computing the counter width $clog2(WIDTH) (minimum 1).
- Sub-module bcd_adj_digit: combinational 4-bit add-3-if->=5 correction, instantiated DIGITS times in a generate loop.
- The main module holds the FSM, counter, shift registers and output registers.

Test Plan:
- Reset with defaults: digits=000000, ovf=0, done=0, in_ready=1. Assert rst_n low mid-SHIFT -> same values immediately, with no done pulse afterwards.
- Input 123456 -> exactly 20 cycles after accept: digits[5..0]=1,2,3,4,5,6, ovf=0, single-cycle done, in_ready back to 1.
- Boundary values:
  - 0 -> 000000, ovf=0.
  - 9 -> 000009.
  - 10 -> 000010.
  - 999999 -> 999999, ovf=0.
  - 1000000 -> 999999, ovf=1.
  - 1048575 -> 999999, ovf=1.
- Back-to-back: hold in_valid high with 42 then 7 -> second accept happens in the done cycle. Outputs show 000042 then 000007. During SHIFT, in_ready=0 and in_value changes are ignored.
- Hold check: after a conversion of 5, with in_valid low for 100 cycles -> digits stays 000005 and done stays 0.
- Random sweep of 1000 values against a reference model (including the WIDTH=4, DIGITS=1 configuration): every result matches the decimal expansion or the saturation rule, with the latency and done pulse exactly as specified.
